// File: rtl/gcm_pkg.sv
// Shared types, constants and block-formatting helpers for the AES-GCM sequencer.
package gcm_pkg;

   localparam int          BLK_W           = 128;
   localparam int          IV_W            = 96;
   localparam logic [31:0] J0_SUFFIX       = 32'h1;
   localparam logic [31:0] CTR_INIT_SUFFIX = 32'h2;

   typedef enum logic [3:0] {
      IDLE, HGEN, J0ENC, WAIT_IN, CTRENC, CTOUT, GMUL, LEN, TAG, DONE
   } state_e;

   // Only the low 32-bit word counts; the IV part of the counter never changes.
   function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] c);
      return {c[BLK_W-1:32], c[31:0] + 32'd1};
   endfunction

   function automatic logic [BLK_W-1:0] len_block(input logic [63:0] ad_blocks,
                                                  input logic [63:0] pt_blocks);
      logic [63:0] ad_bits;
      logic [63:0] pt_bits;
      ad_bits = ad_blocks << 7;
      pt_bits = pt_blocks << 7;
      return {ad_bits, pt_bits};
   endfunction

endpackage

// File: rtl/gcm_sequencer.sv
// AES-GCM encryption sequencer: drives one shared AES core and one GF(2^128)
// multiplier through req/ack handshakes to produce ciphertext and the tag.
module gcm_sequencer
   import gcm_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             msg_empty,
   input  logic [IV_W-1:0]  iv,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_is_ad,
   input  logic             in_last,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic [BLK_W-1:0] ct_data,
   output logic             aes_req,
   output logic [BLK_W-1:0] aes_in,
   input  logic             aes_ack,
   input  logic [BLK_W-1:0] aes_out,
   output logic             gf_req,
   output logic [BLK_W-1:0] gf_a,
   output logic [BLK_W-1:0] gf_b,
   input  logic             gf_ack,
   input  logic [BLK_W-1:0] gf_p,
   output logic             tag_valid,
   output logic [BLK_W-1:0] tag,
   output logic             busy,
   output logic             err
);

   state_e             state_q;
   logic [IV_W-1:0]    iv_q;
   logic               empty_q;
   logic [BLK_W-1:0]   h_q, ej0_q, y_q, x_q, ctr_q, pt_q, ct_q, tag_q;
   logic [BLK_W-1:0]   aes_in_q, gf_a_q;
   logic [CNT_W-1:0]   ad_cnt_q, pt_cnt_q;
   logic               seen_pt_q, last_q, len_pass_q;
   logic               aes_req_q, gf_req_q, in_ready_q, ct_valid_q;
   logic               tag_valid_q, busy_q, err_q;
   logic               blk_drop_d;

   // AD is only legal before the first PT block; a full counter refuses more blocks.
   assign blk_drop_d = in_is_ad ? (seen_pt_q || (&ad_cnt_q)) : (&pt_cnt_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         iv_q        <= '0;
         empty_q     <= 1'b0;
         h_q         <= '0;
         ej0_q       <= '0;
         y_q         <= '0;
         x_q         <= '0;
         ctr_q       <= '0;
         pt_q        <= '0;
         ct_q        <= '0;
         tag_q       <= '0;
         aes_in_q    <= '0;
         gf_a_q      <= '0;
         ad_cnt_q    <= '0;
         pt_cnt_q    <= '0;
         seen_pt_q   <= 1'b0;
         last_q      <= 1'b0;
         len_pass_q  <= 1'b0;
         aes_req_q   <= 1'b0;
         gf_req_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         ct_valid_q  <= 1'b0;
         tag_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  iv_q        <= iv;
                  empty_q     <= msg_empty;
                  y_q         <= '0;
                  ad_cnt_q    <= '0;
                  pt_cnt_q    <= '0;
                  seen_pt_q   <= 1'b0;
                  last_q      <= 1'b0;
                  len_pass_q  <= 1'b0;
                  err_q       <= 1'b0;
                  tag_valid_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= HGEN;
               end
            end
            HGEN: begin
               if (!aes_req_q) begin
                  aes_req_q <= 1'b1;
                  aes_in_q  <= '0;
               end else if (aes_ack) begin
                  aes_req_q <= 1'b0;
                  h_q       <= aes_out;
                  state_q   <= J0ENC;
               end
            end
            J0ENC: begin
               if (!aes_req_q) begin
                  aes_req_q <= 1'b1;
                  aes_in_q  <= {iv_q, J0_SUFFIX};
               end else if (aes_ack) begin
                  aes_req_q <= 1'b0;
                  ej0_q     <= aes_out;
                  ctr_q     <= {iv_q, CTR_INIT_SUFFIX};
                  if (empty_q) begin
                     state_q <= LEN;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= WAIT_IN;
                  end
               end
            end
            WAIT_IN: begin
               if (in_valid && in_ready_q) begin
                  if (blk_drop_d) begin
                     err_q <= 1'b1;
                     if (in_last) begin
                        in_ready_q <= 1'b0;
                        state_q    <= LEN;
                     end
                  end else if (in_is_ad) begin
                     ad_cnt_q   <= ad_cnt_q + CNT_W'(1);
                     x_q        <= in_data;
                     last_q     <= in_last;
                     in_ready_q <= 1'b0;
                     state_q    <= GMUL;
                  end else begin
                     pt_cnt_q   <= pt_cnt_q + CNT_W'(1);
                     pt_q       <= in_data;
                     seen_pt_q  <= 1'b1;
                     last_q     <= in_last;
                     in_ready_q <= 1'b0;
                     state_q    <= CTRENC;
                  end
               end
            end
            CTRENC: begin
               if (!aes_req_q) begin
                  aes_req_q <= 1'b1;
                  aes_in_q  <= ctr_q;
               end else if (aes_ack) begin
                  aes_req_q  <= 1'b0;
                  ct_q       <= pt_q ^ aes_out;
                  ctr_q      <= inc32(ctr_q);
                  ct_valid_q <= 1'b1;
                  state_q    <= CTOUT;
               end
            end
            CTOUT: begin
               if (ct_ready) begin
                  ct_valid_q <= 1'b0;
                  x_q        <= ct_q;
                  state_q    <= GMUL;
               end
            end
            GMUL: begin
               if (!gf_req_q) begin
                  gf_req_q <= 1'b1;
                  gf_a_q   <= y_q ^ x_q;
               end else if (gf_ack) begin
                  gf_req_q <= 1'b0;
                  y_q      <= gf_p;
                  if (len_pass_q) begin
                     state_q <= TAG;
                  end else if (last_q) begin
                     state_q <= LEN;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= WAIT_IN;
                  end
               end
            end
            LEN: begin
               x_q        <= len_block(64'(ad_cnt_q), 64'(pt_cnt_q));
               len_pass_q <= 1'b1;
               state_q    <= GMUL;
            end
            TAG: begin
               tag_q       <= y_q ^ ej0_q;
               tag_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign ct_valid  = ct_valid_q;
   assign ct_data   = ct_q;
   assign aes_req   = aes_req_q;
   assign aes_in    = aes_in_q;
   assign gf_req    = gf_req_q;
   assign gf_a      = gf_a_q;
   assign gf_b      = h_q;
   assign tag_valid = tag_valid_q;
   assign tag       = tag_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
